// File: rtl/fetch_pc_unit.sv
// Program counter and single-outstanding instruction fetch front end with EX redirect/flush.
// Optional misaligned-target trap is enabled by defining FETCH_MISALIGN_TRAP_EN.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        pcjump_i,
  input  logic        rs1pc_i,
  input  logic [31:0] ex_pc_i,
  input  logic [31:0] ex_imm_i,
  input  logic [31:0] rs1data_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic        if_valid_o,
  input  logic        if_ready_i,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_instr_o,
  output logic        fetch_misalign_o
);

  typedef enum logic [1:0] {StIdle, StFetch, StHold, StFlush} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] addr_q, addr_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic        misalign_q, misalign_d;
  logic [31:0] raw_tgt;
  logic [31:0] tgt;

  always_comb begin
    raw_tgt = rs1pc_i ? ((rs1data_i + ex_imm_i) & ~32'h1) : (ex_pc_i + ex_imm_i);
`ifdef FETCH_MISALIGN_TRAP_EN
    tgt        = raw_tgt[1] ? TRAP_VEC : raw_tgt;
    misalign_d = pcjump_i & raw_tgt[1];
`else
    tgt        = raw_tgt & ~32'h3;
    misalign_d = 1'b0;
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      pc_q       <= RESET_PC;
      addr_q     <= RESET_PC;
      if_valid_q <= 1'b0;
      if_pc_q    <= 32'h0;
      if_instr_q <= 32'h0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      addr_q     <= addr_d;
      if_valid_q <= if_valid_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
      misalign_q <= misalign_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    addr_d     = addr_q;
    if_valid_d = if_valid_q;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;
    unique case (state_q)
      StIdle: begin
        state_d = StFetch;
        addr_d  = pc_q;
        if (pcjump_i) begin
          pc_d   = tgt;
          addr_d = tgt;
        end
      end
      StFetch: begin
        if (pcjump_i) begin
          pc_d = tgt;
          if (imem_ack_i) begin
            addr_d  = tgt;
            state_d = StFetch;
          end else begin
            // Request already in flight: wait out its ack before reissuing.
            state_d = StFlush;
          end
        end else if (imem_ack_i) begin
          if_instr_d = imem_rdata_i;
          if_pc_d    = addr_q;
          if_valid_d = 1'b1;
          state_d    = StHold;
        end
      end
      StHold: begin
        if (pcjump_i) begin
          pc_d    = tgt;
          addr_d  = tgt;
          state_d = StFetch;
        end else if (if_ready_i) begin
          pc_d       = pc_q + 32'd4;
          addr_d     = pc_q + 32'd4;
          if_valid_d = 1'b0;
          state_d    = StFetch;
        end
      end
      StFlush: begin
        if (pcjump_i) begin
          pc_d = tgt;
          if (imem_ack_i) begin
            addr_d  = tgt;
            state_d = StFetch;
          end
        end else if (imem_ack_i) begin
          addr_d  = pc_q;
          state_d = StFetch;
        end
      end
      default: state_d = StIdle;
    endcase
    // A redirect always kills the held instruction.
    if (pcjump_i) begin
      if_valid_d = 1'b0;
    end
  end

  always_comb begin
    imem_req_o       = (state_q == StFetch) || (state_q == StFlush);
    imem_addr_o      = addr_q;
    if_valid_o       = if_valid_q;
    if_pc_o          = if_pc_q;
    if_instr_o       = if_instr_q;
    fetch_misalign_o = misalign_q;
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed self-checking bench for fetch_pc_unit; inputs driven and outputs sampled on negedge.
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pcjump, rs1pc;
  logic [31:0] ex_pc, ex_imm, rs1data;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid, if_ready;
  logic [31:0] if_pc, if_instr;
  logic        fetch_misalign;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_pc_unit dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .pcjump_i        (pcjump),
    .rs1pc_i         (rs1pc),
    .ex_pc_i         (ex_pc),
    .ex_imm_i        (ex_imm),
    .rs1data_i       (rs1data),
    .imem_req_o      (imem_req),
    .imem_addr_o     (imem_addr),
    .imem_ack_i      (imem_ack),
    .imem_rdata_i    (imem_rdata),
    .if_valid_o      (if_valid),
    .if_ready_i      (if_ready),
    .if_pc_o         (if_pc),
    .if_instr_o      (if_instr),
    .fetch_misalign_o(fetch_misalign)
  );

  task automatic step();
    @(negedge clk);
  endtask

  // Respond to the outstanding request for exactly one cycle.
  task automatic ack_once(input logic [31:0] data);
    imem_ack   = 1'b1;
    imem_rdata = data;
    step();
    imem_ack   = 1'b0;
  endtask

  task automatic jump(input logic sel, input logic [31:0] pc, input logic [31:0] imm,
                      input logic [31:0] rs1);
    pcjump  = 1'b1;
    rs1pc   = sel;
    ex_pc   = pc;
    ex_imm  = imm;
    rs1data = rs1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pcjump = 1'b0; rs1pc = 1'b0; ex_pc = 32'h0; ex_imm = 32'h0;
    rs1data = 32'h0; imem_ack = 1'b0; imem_rdata = 32'h0; if_ready = 1'b0;
    step(); step();
    checks++;
    if ({imem_req, imem_addr, if_valid, if_pc, if_instr, fetch_misalign} !== {1'b0, 32'h0, 1'b0,
        32'h0, 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: req=%b addr=%h valid=%b pc=%h instr=%h mis=%b, want all zero",
               imem_req, imem_addr, if_valid, if_pc, if_instr, fetch_misalign);
    end
    rst_n = 1'b1;
    checks++;
    if (imem_req !== 1'b0) begin
      errors++; $display("FAIL idle_no_req: req=%b want 0", imem_req);
    end
    step();
    checks++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
      errors++; $display("FAIL first_req: req=%b addr=%h want 1/00000000", imem_req, imem_addr);
    end
    ack_once(32'h1111_1111);
    checks++;
    if ({if_valid, if_pc, if_instr, imem_req} !== {1'b1, 32'h0, 32'h1111_1111, 1'b0}) begin
      errors++;
      $display("FAIL first_fetch: valid=%b pc=%h instr=%h req=%b want 1/0/11111111/0",
               if_valid, if_pc, if_instr, imem_req);
    end
  endtask

  task automatic test_sequential();
    if_ready = 1'b1;
    step();
    checks++;
    if ({imem_req, imem_addr, if_valid} !== {1'b1, 32'h4, 1'b0}) begin
      errors++; $display("FAIL seq_req4: req=%b addr=%h valid=%b want 1/4/0",
                         imem_req, imem_addr, if_valid);
    end
    ack_once(32'h2222_2222);
    checks++;
    if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h4, 32'h2222_2222}) begin
      errors++; $display("FAIL seq_out4: valid=%b pc=%h instr=%h want 1/4/22222222",
                         if_valid, if_pc, if_instr);
    end
    step();
    checks++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h8}) begin
      errors++; $display("FAIL seq_req8: req=%b addr=%h want 1/8", imem_req, imem_addr);
    end
    ack_once(32'h3333_3333);
    if_ready = 1'b0;
    checks++;
    if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h8, 32'h3333_3333}) begin
      errors++; $display("FAIL seq_out8: valid=%b pc=%h instr=%h want 1/8/33333333",
                         if_valid, if_pc, if_instr);
    end
  endtask

  task automatic test_hold_stall();
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if ({if_valid, if_pc, if_instr, imem_req} !== {1'b1, 32'h8, 32'h3333_3333, 1'b0}) begin
        errors++;
        $display("FAIL stall_%0d: valid=%b pc=%h instr=%h req=%b want 1/8/33333333/0",
                 i, if_valid, if_pc, if_instr, imem_req);
      end
    end
    if_ready = 1'b1;
    step();
    if_ready = 1'b0;
    checks++;
    if ({imem_req, imem_addr} !== {1'b1, 32'hC}) begin
      errors++; $display("FAIL stall_pc: req=%b addr=%h want 1/0000000c", imem_req, imem_addr);
    end
  endtask

  task automatic test_flush();
    jump(1'b0, 32'h40, 32'hFFFF_FFF8, 32'h0);
    step();
    pcjump = 1'b0;
    step();
    checks++;
    if ({imem_req, imem_addr, if_valid} !== {1'b1, 32'hC, 1'b0}) begin
      errors++; $display("FAIL flush_hold_addr: req=%b addr=%h valid=%b want 1/c/0",
                         imem_req, imem_addr, if_valid);
    end
    ack_once(32'hDEAD_BEEF);
    checks++;
    if ({imem_req, imem_addr, if_valid} !== {1'b1, 32'h38, 1'b0}) begin
      errors++; $display("FAIL flush_redirect: req=%b addr=%h valid=%b want 1/38/0",
                         imem_req, imem_addr, if_valid);
    end
    ack_once(32'h4444_4444);
    checks++;
    if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h38, 32'h4444_4444}) begin
      errors++; $display("FAIL flush_fetch: valid=%b pc=%h instr=%h want 1/38/44444444",
                         if_valid, if_pc, if_instr);
    end
  endtask

  task automatic test_redirect_hold();
    if_ready = 1'b1;
    jump(1'b0, 32'h200, 32'h10, 32'h0);
    step();
    pcjump = 1'b0; if_ready = 1'b0;
    checks++;
    if ({if_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h210}) begin
      errors++; $display("FAIL hold_jump: valid=%b req=%b addr=%h want 0/1/210",
                         if_valid, imem_req, imem_addr);
    end
    ack_once(32'h5555_5555);
    checks++;
    if ({if_valid, if_pc} !== {1'b1, 32'h210}) begin
      errors++; $display("FAIL hold_jump_fetch: valid=%b pc=%h want 1/210", if_valid, if_pc);
    end
  endtask

  task automatic test_wrap();
    jump(1'b1, 32'h0, 32'hC, 32'hFFFF_FFF0);
    step();
    pcjump = 1'b0;
    checks++;
    if ({imem_req, imem_addr} !== {1'b1, 32'hFFFF_FFFC}) begin
      errors++; $display("FAIL wrap_top: req=%b addr=%h want 1/fffffffc", imem_req, imem_addr);
    end
    ack_once(32'h6666_6666);
    checks++;
    if ({if_valid, if_pc} !== {1'b1, 32'hFFFF_FFFC}) begin
      errors++; $display("FAIL wrap_out: valid=%b pc=%h want 1/fffffffc", if_valid, if_pc);
    end
    if_ready = 1'b1;
    step();
    if_ready = 1'b0;
    checks++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
      errors++; $display("FAIL wrap_zero: req=%b addr=%h want 1/0", imem_req, imem_addr);
    end
  endtask

  task automatic test_misalign();
    logic        exp_mis;
    logic [31:0] exp_addr;
`ifdef FETCH_MISALIGN_TRAP_EN
    exp_mis = 1'b1; exp_addr = 32'h100;
`else
    exp_mis = 1'b0; exp_addr = 32'h1000;
`endif
    ack_once(32'h7777_7777);
    jump(1'b1, 32'h0, 32'h0, 32'h1003);
    step();
    pcjump = 1'b0;
    checks++;
    if ({fetch_misalign, imem_req, imem_addr} !== {exp_mis, 1'b1, exp_addr}) begin
      errors++; $display("FAIL misalign: mis=%b req=%b addr=%h want %b/1/%h",
                         fetch_misalign, imem_req, imem_addr, exp_mis, exp_addr);
    end
    step();
    checks++;
    if (fetch_misalign !== 1'b0) begin
      errors++; $display("FAIL misalign_pulse: mis=%b want 0", fetch_misalign);
    end
  endtask

  task automatic test_ack_with_jump();
    imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0;
    jump(1'b0, 32'h80, 32'h4, 32'h0);
    step();
    pcjump = 1'b0; imem_ack = 1'b0;
    checks++;
    if ({if_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h84}) begin
      errors++; $display("FAIL ack_jump: valid=%b req=%b addr=%h want 0/1/84",
                         if_valid, imem_req, imem_addr);
    end
    ack_once(32'h8888_8888);
    checks++;
    if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h84, 32'h8888_8888}) begin
      errors++; $display("FAIL ack_jump_fetch: valid=%b pc=%h instr=%h want 1/84/88888888",
                         if_valid, if_pc, if_instr);
    end
  endtask

  task automatic test_back_to_back_jumps();
    if_ready = 1'b1;
    step();
    if_ready = 1'b0;
    jump(1'b0, 32'h300, 32'h0, 32'h0);
    step();
    jump(1'b0, 32'h400, 32'h0, 32'h0);
    step();
    pcjump = 1'b0;
    checks++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h88}) begin
      errors++; $display("FAIL rejump_flush: req=%b addr=%h want 1/88", imem_req, imem_addr);
    end
    ack_once(32'h9999_9999);
    checks++;
    if ({if_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h400}) begin
      errors++; $display("FAIL rejump_latest: valid=%b req=%b addr=%h want 0/1/400",
                         if_valid, imem_req, imem_addr);
    end
  endtask

  task automatic test_reset_midfetch();
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({imem_req, imem_addr, if_valid, if_pc} !== {1'b0, 32'h0, 1'b0, 32'h0}) begin
      errors++; $display("FAIL midfetch_reset: req=%b addr=%h valid=%b pc=%h want 0/0/0/0",
                         imem_req, imem_addr, if_valid, if_pc);
    end
    step();
    rst_n = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hAAAA_AAAA;
    step();
    imem_ack = 1'b0;
    checks++;
    if ({imem_req, imem_addr, if_valid} !== {1'b1, 32'h0, 1'b0}) begin
      errors++; $display("FAIL late_ack: req=%b addr=%h valid=%b want 1/0/0",
                         imem_req, imem_addr, if_valid);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_hold_stall();
    test_flush();
    test_redirect_hold();
    test_wrap();
    test_misalign();
    test_ack_with_jump();
    test_back_to_back_jumps();
    test_reset_midfetch();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
